// File: rtl/shift_reg_sequencer.sv
// shift_reg_sequencer: command-driven controller for a 4-bit shift/load register datapath
module shift_reg_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             cmd_fill,
  input  logic [WIDTH-1:0] load_data,
  input  logic [WIDTH-1:0] q,
  output logic [1:0]       mode,
  output logic [WIDTH-1:0] par_data,
  output logic             ser_in,
  output logic             mux_enb,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] step_cnt
);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SHR  = 2'b10;
  localparam logic [1:0] OP_ROL  = 2'b11;
  state_t           r_state, w_next;
  logic [1:0]       r_op, r_mode, w_mode;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [WIDTH-1:0] r_par, w_par;
  logic             r_ser, w_ser, r_done, w_done, r_enb, w_accept;
  assign cmd_ready = (r_state == IDLE) && !reset && !r_enb;
  assign w_accept  = cmd_valid && cmd_ready;
  assign mode      = r_mode;
  assign par_data  = r_par;
  assign mux_enb   = r_enb;
  assign busy      = r_state != IDLE;
  assign done      = r_done;
  assign step_cnt  = r_cnt;
  // rotate feeds the MSB back combinationally so each step sees the current register value
  assign ser_in    = (r_state == SHIFT && r_op == OP_ROL) ? q[WIDTH-1] : r_ser;
  // next state and next registered outputs; mode falls back to hold unless actively loading/shifting
  always_comb begin
    w_next = r_state;
    w_cnt  = r_cnt;
    w_mode = 2'b00;
    w_par  = r_par;
    w_ser  = r_ser;
    w_done = 1'b0;
    case (r_state)
      IDLE: if (w_accept) begin
        if (cmd_op == OP_LOAD) begin
          w_next = LOAD;
          w_mode = 2'b11;
          w_par  = load_data;
        end else begin
          w_ser  = (cmd_op == OP_ROL) ? 1'b0 : cmd_fill;
          w_next = (cmd_count == '0) ? DONE : SHIFT;
          w_done = cmd_count == '0;
          w_cnt  = cmd_count;
          w_mode = (cmd_count == '0) ? 2'b00 : (cmd_op == OP_SHR) ? 2'b10 : 2'b01;
        end
      end
      LOAD: begin
        w_next = DONE;
        w_done = 1'b1;
      end
      SHIFT: begin
        w_cnt  = r_cnt - 1'b1;
        w_next = (r_cnt == 1) ? DONE : SHIFT;
        w_done = r_cnt == 1;
        w_mode = (r_cnt == 1) ? 2'b00 : (r_op == OP_SHR) ? 2'b10 : 2'b01;
      end
      default: w_next = IDLE;
    endcase
  end
  // state and output registers; the MUX stays disabled until the first cycle out of reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_op    <= OP_LOAD;
      r_cnt   <= '0;
      r_mode  <= 2'b00;
      r_par   <= '0;
      r_ser   <= 1'b0;
      r_done  <= 1'b0;
      r_enb   <= 1'b1;
    end else begin
      r_state <= w_next;
      r_op    <= w_accept ? cmd_op : r_op;
      r_cnt   <= w_cnt;
      r_mode  <= w_mode;
      r_par   <= w_par;
      r_ser   <= w_ser;
      r_done  <= w_done;
      r_enb   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_shift_reg_sequencer.sv
// tb_shift_reg_sequencer: table-driven check of the sequencer with a behavioural datapath model
module tb_shift_reg_sequencer;
  logic       clk = 1'b0, reset = 1'b1, cmd_valid = 1'b0, cmd_fill = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [2:0] cmd_count = 3'd0;
  logic [3:0] load_data = 4'd0;
  logic [3:0] q, par_data;
  logic [1:0] mode;
  logic [2:0] step_cnt;
  logic       cmd_ready, ser_in, mux_enb, busy, done;
  int         n_chk = 0, n_err = 0;

  typedef struct {
    logic       rst, val;
    logic [1:0] op;
    logic [2:0] cnt;
    logic       fill;
    logic [3:0] ld;
    logic [1:0] e_mode;
    logic       e_ser, ser_chk, e_enb, e_busy, e_done;
    logic [2:0] e_cnt;
    logic       e_rdy;
    logic [3:0] e_q;
  } vec_t;
  vec_t v[$];

  shift_reg_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_count(cmd_count), .cmd_fill(cmd_fill), .load_data(load_data),
    .q(q), .mode(mode), .par_data(par_data), .ser_in(ser_in), .mux_enb(mux_enb),
    .busy(busy), .done(done), .step_cnt(step_cnt)
  );

  always #5 clk = ~clk;

  // register datapath: shift left/right through ser_in, parallel load, gated by the active-low enable
  always_ff @(posedge clk) begin
    if (reset) q <= 4'd0;
    else if (!mux_enb && mode == 2'b01) q <= {q[2:0], ser_in};
    else if (!mux_enb && mode == 2'b10) q <= {ser_in, q[3:1]};
    else if (!mux_enb && mode == 2'b11) q <= par_data;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input logic [1:0] em, input logic es, input logic sc,
                           input logic ee, input logic eb, input logic ed, input logic [2:0] ec,
                           input logic er, input logic [3:0] eq, input logic qc);
    chk("mode", idx, 8'(mode), 8'(em));
    if (sc) chk("ser_in", idx, 8'(ser_in), 8'(es));
    chk("mux_enb", idx, 8'(mux_enb), 8'(ee));
    chk("busy", idx, 8'(busy), 8'(eb));
    chk("done", idx, 8'(done), 8'(ed));
    chk("step_cnt", idx, 8'(step_cnt), 8'(ec));
    chk("cmd_ready", idx, 8'(cmd_ready), 8'(er));
    if (qc) chk("q", idx, 8'(q), 8'(eq));
  endtask

  initial begin
    // rst val op cnt fill ld | mode ser sc enb busy done cnt rdy q
    v.push_back('{1, 0, 2'b00, 0, 0, 4'h0, 2'b00, 0, 1, 1, 0, 0, 0, 0, 4'b0000});
    v.push_back('{1, 0, 2'b00, 0, 0, 4'h0, 2'b00, 0, 1, 1, 0, 0, 0, 0, 4'b0000});
    v.push_back('{0, 0, 2'b00, 0, 0, 4'h0, 2'b00, 0, 1, 0, 0, 0, 0, 1, 4'b0000});
    v.push_back('{0, 1, 2'b00, 0, 0, 4'hb, 2'b11, 0, 1, 0, 1, 0, 0, 0, 4'b0000});
    v.push_back('{0, 0, 2'b00, 0, 0, 4'h0, 2'b00, 0, 1, 0, 1, 1, 0, 0, 4'b1011});
    v.push_back('{0, 0, 2'b00, 0, 0, 4'h0, 2'b00, 0, 1, 0, 0, 0, 0, 1, 4'b1011});
    v.push_back('{0, 1, 2'b01, 2, 0, 4'h0, 2'b01, 0, 1, 0, 1, 0, 2, 0, 4'b1011});
    v.push_back('{0, 0, 2'b00, 0, 0, 4'h0, 2'b01, 0, 1, 0, 1, 0, 1, 0, 4'b0110});
    v.push_back('{0, 0, 2'b00, 0, 0, 4'h0, 2'b00, 0, 1, 0, 1, 1, 0, 0, 4'b1100});
    v.push_back('{0, 0, 2'b00, 0, 0, 4'h0, 2'b00, 0, 1, 0, 0, 0, 0, 1, 4'b1100});
    v.push_back('{0, 1, 2'b00, 0, 0, 4'h9, 2'b11, 0, 1, 0, 1, 0, 0, 0, 4'b1100});
    v.push_back('{0, 0, 2'b00, 0, 0, 4'h0, 2'b00, 0, 1, 0, 1, 1, 0, 0, 4'b1001});
    v.push_back('{0, 0, 2'b00, 0, 0, 4'h0, 2'b00, 0, 1, 0, 0, 0, 0, 1, 4'b1001});
    v.push_back('{0, 1, 2'b11, 3, 1, 4'h0, 2'b01, 1, 1, 0, 1, 0, 3, 0, 4'b1001});
    v.push_back('{0, 0, 2'b00, 0, 0, 4'h0, 2'b01, 0, 1, 0, 1, 0, 2, 0, 4'b0011});
    v.push_back('{0, 0, 2'b00, 0, 0, 4'h0, 2'b01, 0, 1, 0, 1, 0, 1, 0, 4'b0110});
    v.push_back('{0, 0, 2'b00, 0, 0, 4'h0, 2'b00, 0, 0, 0, 1, 1, 0, 0, 4'b1100});
    v.push_back('{0, 0, 2'b00, 0, 0, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 4'b1100});
    v.push_back('{0, 1, 2'b10, 1, 1, 4'h0, 2'b10, 1, 1, 0, 1, 0, 1, 0, 4'b1100});
    v.push_back('{0, 0, 2'b00, 0, 0, 4'h0, 2'b00, 0, 0, 0, 1, 1, 0, 0, 4'b1110});
    v.push_back('{0, 0, 2'b00, 0, 0, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 4'b1110});
    for (int i = 0; i < v.size(); i++) begin
      reset = v[i].rst; cmd_valid = v[i].val; cmd_op = v[i].op;
      cmd_count = v[i].cnt; cmd_fill = v[i].fill; load_data = v[i].ld;
      step();
      check_all(i, v[i].e_mode, v[i].e_ser, v[i].ser_chk, v[i].e_enb, v[i].e_busy,
                v[i].e_done, v[i].e_cnt, v[i].e_rdy, v[i].e_q, 1'b1);
    end
    // zero-count shift completes immediately; a held-valid command waits until after DONE
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_count = 3'd0; cmd_fill = 1'b0;
    step();
    check_all(100, 2'b00, 0, 0, 0, 1, 1, 3'd0, 0, 4'b1110, 1);
    cmd_op = 2'b00; load_data = 4'b0101;
    step();
    check_all(101, 2'b00, 0, 0, 0, 0, 0, 3'd0, 1, 4'b1110, 1);
    step();
    check_all(102, 2'b11, 0, 0, 0, 1, 0, 3'd0, 0, 4'b1110, 1);
    chk("par_data", 102, 8'(par_data), 8'h05);
    cmd_valid = 1'b0;
    step();
    check_all(103, 2'b00, 0, 0, 0, 1, 1, 3'd0, 0, 4'b0101, 1);
    step();
    check_all(104, 2'b00, 0, 0, 0, 0, 0, 3'd0, 1, 4'b0101, 1);
    // reset two steps into a 5-step shift right aborts with no done pulse
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_count = 3'd5; cmd_fill = 1'b0;
    step();
    check_all(200, 2'b10, 0, 1, 0, 1, 0, 3'd5, 0, 4'b0101, 1);
    cmd_valid = 1'b0;
    step();
    check_all(201, 2'b10, 0, 1, 0, 1, 0, 3'd4, 0, 4'b0010, 1);
    step();
    check_all(202, 2'b10, 0, 1, 0, 1, 0, 3'd3, 0, 4'b0001, 1);
    reset = 1'b1;
    step();
    check_all(203, 2'b00, 0, 1, 1, 0, 0, 3'd0, 0, 4'b0000, 0);
    step();
    check_all(204, 2'b00, 0, 1, 1, 0, 0, 3'd0, 0, 4'b0000, 0);
    reset = 1'b0;
    step();
    check_all(205, 2'b00, 0, 1, 0, 0, 0, 3'd0, 1, 4'b0000, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
